// File: rtl/regfile_pkg.sv
// regfile_pkg: default sizes and packed-bus slice helper for the register file
package regfile_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int READ_PORTS = 2;
  localparam int MAX_BUS = 256;
  function automatic logic [MAX_BUS-1:0] sliceOf(input logic [MAX_BUS-1:0] packedBus, input int p, input int w);
    return (packedBus >> (p * w)) & ((MAX_BUS'(1) << w) - MAX_BUS'(1));
  endfunction
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: decode/writeback bus of the multi-port register file
interface regfile_mp_if #(
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter int READ_PORTS = regfile_pkg::READ_PORTS
);
  logic [READ_PORTS*ADDR_WIDTH-1:0] rd_addr;
  logic [READ_PORTS*DATA_WIDTH-1:0] rd_data;
  logic [READ_PORTS-1:0] rd_busy;
  logic wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic rsv_en;
  logic [ADDR_WIDTH-1:0] rsv_addr;
  logic wb_err;
  logic err_clr;
  modport master(output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, err_clr, input rd_data, rd_busy, wb_err);
  modport slave(input rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, err_clr, output rd_data, rd_busy, wb_err);
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits and sticky bad-writeback flag
module regfile_scoreboard #(
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic wrEn,
  input  logic [ADDR_WIDTH-1:0] wrAddr,
  input  logic rsvEn,
  input  logic [ADDR_WIDTH-1:0] rsvAddr,
  input  logic errClr,
  output logic [2**ADDR_WIDTH-1:0] busy,
  output logic wbErr
);
  logic [2**ADDR_WIDTH-1:0] busyNext;
  logic wrValid, rsvValid;
  assign wrValid = wrEn && !(ZERO_REG && wrAddr == '0);
  assign rsvValid = rsvEn && !(ZERO_REG && rsvAddr == '0);
  // Reserve is applied after release so a new producer wins on the same register
  always_comb begin
    busyNext = busy;
    if (wrEn) busyNext[wrAddr] = 1'b0;
    if (rsvValid) busyNext[rsvAddr] = 1'b1;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
      wbErr <= 1'b0;
    end else begin
      busy <= busyNext;
      wbErr <= (wrValid && !busy[wrAddr]) || (wbErr && !errClr);
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port register file with bypass,
// hardwired zero register and busy scoreboard
module regfile_mp import regfile_pkg::*; #(
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter int READ_PORTS = regfile_pkg::READ_PORTS,
  parameter bit BYPASS = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input logic clock,
  input logic reset_n,
  regfile_mp_if.slave bus
);
  localparam int NUM_REGS = 2**ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic wrValid;
  assign wrValid = bus.wr_en && !(ZERO_REG && bus.wr_addr == '0);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) regs <= '{default: '0};
    else if (wrValid) regs[bus.wr_addr] <= bus.wr_data;
  end
  regfile_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH), .ZERO_REG(ZERO_REG)) scoreboard (
    .clock(clock),
    .reset_n(reset_n),
    .wrEn(bus.wr_en),
    .wrAddr(bus.wr_addr),
    .rsvEn(bus.rsv_en),
    .rsvAddr(bus.rsv_addr),
    .errClr(bus.err_clr),
    .busy(busy),
    .wbErr(bus.wb_err)
  );
  for (genvar p = 0; p < READ_PORTS; p++) begin : gRead
    logic [ADDR_WIDTH-1:0] addr;
    logic isZero, hit;
    assign addr = ADDR_WIDTH'(sliceOf(MAX_BUS'(bus.rd_addr), p, ADDR_WIDTH));
    assign isZero = ZERO_REG && addr == '0;
    // A same-cycle writeback both forwards its data and hides the stale busy bit
    assign hit = BYPASS && wrValid && bus.wr_addr == addr;
    assign bus.rd_data[p*DATA_WIDTH +: DATA_WIDTH] = isZero ? '0 : hit ? bus.wr_data : regs[addr];
    assign bus.rd_busy[p] = !isZero && !hit && busy[addr];
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed plus random check of regfile_mp (BYPASS=1 and BYPASS=0,
// four read ports) against an array-based reference model
module tb_regfile_mp;
  localparam int DW = 32, AW = 5, RP = 4, NR = 32;
  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic [RP*AW-1:0] rdAddr = '0;
  logic wrEn = 1'b0, rsvEn = 1'b0, errClr = 1'b0;
  logic [AW-1:0] wrAddr = '0, rsvAddr = '0;
  logic [DW-1:0] wrData = '0;
  int errors = 0, checks = 0;
  bit checkOn = 1'b0;

  regfile_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(RP)) busB();
  regfile_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(RP)) busN();
  assign busB.rd_addr = rdAddr;   assign busN.rd_addr = rdAddr;
  assign busB.wr_en = wrEn;       assign busN.wr_en = wrEn;
  assign busB.wr_addr = wrAddr;   assign busN.wr_addr = wrAddr;
  assign busB.wr_data = wrData;   assign busN.wr_data = wrData;
  assign busB.rsv_en = rsvEn;     assign busN.rsv_en = rsvEn;
  assign busB.rsv_addr = rsvAddr; assign busN.rsv_addr = rsvAddr;
  assign busB.err_clr = errClr;   assign busN.err_clr = errClr;

  regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(RP), .BYPASS(1'b1), .ZERO_REG(1'b1))
    dutB (.clock(clock), .reset_n(reset_n), .bus(busB));
  regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(RP), .BYPASS(1'b0), .ZERO_REG(1'b1))
    dutN (.clock(clock), .reset_n(reset_n), .bus(busN));

  always #5 clock = ~clock;

  logic [DW-1:0] mReg [NR];
  bit mBusy [NR];
  bit mErr;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      foreach (mReg[i]) mReg[i] <= '0;
      foreach (mBusy[i]) mBusy[i] <= 1'b0;
      mErr <= 1'b0;
    end else begin
      mErr <= (wrEn && wrAddr != 0 && !mBusy[wrAddr]) || (mErr && !errClr);
      if (wrEn && wrAddr != 0) mReg[wrAddr] <= wrData;
      if (wrEn) mBusy[wrAddr] <= 1'b0;
      if (rsvEn && rsvAddr != 0) mBusy[rsvAddr] <= 1'b1;
    end
  end

  function automatic logic [DW-1:0] expData(int a, bit byp);
    if (a == 0) return '0;
    if (byp && wrEn && int'(wrAddr) == a) return wrData;
    return mReg[a];
  endfunction

  function automatic bit expBusy(int a, bit byp);
    if (a == 0) return 1'b0;
    if (byp && wrEn && int'(wrAddr) == a) return 1'b0;
    return mBusy[a];
  endfunction

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic compareAll();
    for (int p = 0; p < RP; p++) begin
      int a = int'(rdAddr[p*AW +: AW]);
      check($sformatf("dataB[%0d]", p), busB.rd_data[p*DW +: DW], expData(a, 1'b1));
      check($sformatf("dataN[%0d]", p), busN.rd_data[p*DW +: DW], expData(a, 1'b0));
      check($sformatf("busyB[%0d]", p), 32'(busB.rd_busy[p]), 32'(expBusy(a, 1'b1)));
      check($sformatf("busyN[%0d]", p), 32'(busN.rd_busy[p]), 32'(expBusy(a, 1'b0)));
    end
    check("wbErrB", 32'(busB.wb_err), 32'(mErr));
    check("wbErrN", 32'(busN.wb_err), 32'(mErr));
  endtask

  always @(negedge clock) if (checkOn) compareAll();

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wrEn = 1'b0; rsvEn = 1'b0; errClr = 1'b0;
  endtask

  task automatic setPort(int p, int a);
    rdAddr[p*AW +: AW] = AW'(a);
  endtask

  task automatic write(int a, logic [DW-1:0] d);
    wrEn = 1'b1; wrAddr = AW'(a); wrData = d;
  endtask

  task automatic reserve(int a);
    rsvEn = 1'b1; rsvAddr = AW'(a);
  endtask

  initial begin
    setPort(0, 2); setPort(1, 5); setPort(2, 3); setPort(3, 7);
    #1 reset_n = 1'b0;
    #2;
    check("rst dataB0", busB.rd_data[31:0], 32'h0);
    check("rst dataB1", busB.rd_data[63:32], 32'h0);
    check("rst busyB", 32'(busB.rd_busy), 32'h0);
    check("rst errB", 32'(busB.wb_err), 32'h0);
    check("rst dataN1", busN.rd_data[63:32], 32'h0);
    #9 reset_n = 1'b1;
    checkOn = 1'b1;
    tick(); reserve(2);
    tick(); idle(); write(2, 32'hDEEDDEED);
    #2;
    check("byp dataB", busB.rd_data[31:0], 32'hDEEDDEED);
    check("byp busyB", 32'(busB.rd_busy[0]), 32'h0);
    check("nobyp dataN", busN.rd_data[31:0], 32'h0);
    check("nobyp busyN", 32'(busN.rd_busy[0]), 32'h1);
    tick(); idle();
    #2;
    check("nobyp dataN next", busN.rd_data[31:0], 32'hDEEDDEED);
    check("nobyp busyN next", 32'(busN.rd_busy[0]), 32'h0);
    tick(); write(0, 32'hFFFFFFFF); setPort(0, 0);
    #2;
    check("r0 dataB", busB.rd_data[31:0], 32'h0);
    check("r0 busyB", 32'(busB.rd_busy[0]), 32'h0);
    tick(); idle(); reserve(0);
    tick(); idle();
    #2;
    check("r0 rsv busyB", 32'(busB.rd_busy[0]), 32'h0);
    check("r0 rsv busyN", 32'(busN.rd_busy[0]), 32'h0);
    check("r0 errB", 32'(busB.wb_err), 32'h0);
    tick(); reserve(5);
    tick(); idle(); write(5, 32'hAAAADDDD); reserve(5); setPort(1, 5);
    tick(); idle();
    #2;
    check("wr+rsv dataB", busB.rd_data[63:32], 32'hAAAADDDD);
    check("wr+rsv busyB", 32'(busB.rd_busy[1]), 32'h1);
    check("wr+rsv errB", 32'(busB.wb_err), 32'h0);
    tick(); write(7, 32'hBEEFDEED);
    tick(); idle(); setPort(0, 7);
    #2;
    check("bad wr errB", 32'(busB.wb_err), 32'h1);
    check("bad wr dataB", busB.rd_data[31:0], 32'hBEEFDEED);
    errClr = 1'b1;
    tick(); idle();
    #2;
    check("clr errB", 32'(busB.wb_err), 32'h0);
    write(7, 32'h11112222); errClr = 1'b1;
    tick(); idle();
    #2;
    check("set beats clr errB", 32'(busB.wb_err), 32'h1);
    check("set beats clr errN", 32'(busN.wb_err), 32'h1);
    tick(); write(3, 32'h12345678); setPort(2, 3);
    tick(); idle(); reserve(3);
    #2;
    check("r3 dataN", busN.rd_data[95:64], 32'h12345678);
    tick(); idle();
    #1;
    check("r3 busyB", 32'(busB.rd_busy[2]), 32'h1);
    #1 reset_n = 1'b0;
    #1;
    for (int p = 0; p < RP; p++) begin
      check($sformatf("async dataB[%0d]", p), busB.rd_data[p*DW +: DW], 32'h0);
      check($sformatf("async dataN[%0d]", p), busN.rd_data[p*DW +: DW], 32'h0);
    end
    check("async busyB", 32'(busB.rd_busy), 32'h0);
    check("async errB", 32'(busB.wb_err), 32'h0);
    #3 reset_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      wrEn = 1'($urandom_range(0, 1));
      wrAddr = AW'($urandom_range(0, 7));
      wrData = $urandom;
      rsvEn = 1'($urandom_range(0, 1));
      rsvAddr = AW'($urandom_range(0, 7));
      errClr = ($urandom_range(0, 9) == 0);
      for (int p = 0; p < RP; p++) setPort(p, int'($urandom_range(0, 7)));
    end
    tick(); idle();
    tick();
    checkOn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file with write-enable, hardwired zero register, same-cycle write-to-read bypass and a per-register busy scoreboard. It replaces the fixed 32×32, two-read/one-write, always-writing register file in the processor datapath. Decode reads operands and reserves the destination. Writeback writes results and releases the reservation.

## Interface
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH
- READ_PORTS, 2, number of independent read ports (1..4)
- BYPASS, 1, 1 = write data forwarded to same-cycle reads of the written register; 0 = reads return stored value
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy

- clock  in  1  single clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- rd_addr  in  READ_PORTS*ADDR_WIDTH  packed read indices; port p occupies slice p
- rd_data  out  READ_PORTS*DATA_WIDTH  packed read data, combinational from rd_addr
- rd_busy  out  READ_PORTS  1 = register addressed by port p has an outstanding producer
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_WIDTH  writeback destination
- wr_data  in  DATA_WIDTH  writeback value
- rsv_en  in  1  reserve strobe from decode
- rsv_addr  in  ADDR_WIDTH  destination being reserved
- wb_err  out  1  sticky: writeback to a register that was not busy
- err_clr  in  1  synchronous clear of wb_err

## Operation
- Storage: NUM_REGS × DATA_WIDTH flops. busy[NUM_REGS] scoreboard.
- Reset (async, reset_n low): all registers 0, all busy 0, wb_err 0. Outputs follow: rd_data all 0, rd_busy all 0.
- Write: on rising edge with wr_en=1, regs[wr_addr] <= wr_data. Suppressed when ZERO_REG=1 and wr_addr=0.
- Read: rd_data[p] = regs[rd_addr[p]], with these exceptions:
  - ZERO_REG=1 and rd_addr[p]=0: returns 0.
  - BYPASS=1, wr_en=1, wr_addr=rd_addr[p], address writable: returns wr_data.
- Scoreboard update per edge, for register r:
  - rsv_en & rsv_addr=r sets busy[r].
  - wr_en & wr_addr=r clears busy[r].
  - Both on the same r: set wins, because a new producer has issued.
  - Register 0 is never set when ZERO_REG=1.
- rd_busy[p] = busy[rd_addr[p]], with these exceptions:
  - BYPASS=1 and a same-cycle writeback to that address: 0.
  - Zero register: 0.
- wb_err: set on an edge with wr_en=1 to a writable register whose busy bit was 0 before that edge. Cleared by err_clr; set takes priority over clear. The register write still happens.
- Multiple read ports may address the same register; each returns identical data.

## Timing
- Write latency: 1 edge to storage. 0 cycles to readers with BYPASS=1, 1 cycle without.
- Read path purely combinational: rd_addr/wr_* to rd_data/rd_busy within the same cycle, no registered outputs.
- Reserve visible on rd_busy the cycle after rsv_en.
- Writeback-then-reserve of the same register in consecutive cycles:
  - busy goes 1→0 for one cycle.
  - busy returns to 1 in the following cycle.
- reset_n asserted mid-operation clears state immediately, without waiting for a clock edge. Deassertion is synchronised externally; the block needs no extra handling.
- wr_en with rsv_en to a different register in the same cycle: both take effect independently.

## Structure
- Package regfile_pkg holds:
  - default parameter constants: DATA_WIDTH, ADDR_WIDTH, READ_PORTS
  - function to extract port slice p from packed buses
- Sub-module regfile_scoreboard contains:
  - busy vector
  - set/clear priority logic
  - wb_err
- The top level holds storage, the read mux and the bypass.

## Test plan
- Reset, then read R2 and R5 on ports 0/1 → rd_data 0x00000000 both, rd_busy 00, wb_err 0.
- rsv R2; next cycle wr R2=0xDEEDDEED while port 0 reads R2 → same cycle rd_data[0]=0xDEEDDEED, rd_busy[0]=0 (BYPASS=1). With BYPASS=0, returns 0 that cycle and 0xDEEDDEED the next.
- wr R0=0xFFFFFFFF (ZERO_REG=1) → R0 reads 0, rd_busy 0, no wb_err; rsv R0 has no effect.
- Same cycle wr R5=0xAAAADDDD and rsv R5, with R5 previously busy → next cycle R5 data 0xAAAADDDD, rd_busy=1, wb_err 0.
- wr R7=0xBEEFDEED with R7 not busy → wb_err=1 next cycle, R7 holds 0xBEEFDEED. err_clr → wb_err=0. err_clr coincident with a new bad write → wb_err stays 1.
- Write R3=0x12345678 with READ_PORTS=4, then pull reset_n low between edges → all rd_data 0 and busy cleared immediately, before the next edge.
